// File: rtl/keypad_scanner_fifo.sv
// keypad_scanner_fifo: matrix keypad scanner with frame debounce, ghost rejection and a key-event FIFO.
// Events are {release, code}; rd_data shows the head word whenever the FIFO is non-empty.
module keypad_scanner_fifo #(
    parameter int NROWS      = 4,
    parameter int NCOLS      = 4,
    parameter int SCAN_DIV   = 16,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int REPORT_REL = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic [NCOLS-1:0]                  cols,
    input  logic [NROWS-1:0]                  rows,
    input  logic                              rd_en,
    output logic [31:0]                       rd_data,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              overflow,
    input  logic                              ovf_clr,
    output logic                              key_held,
    output logic [7:0]                        held_code
);
    localparam int CW   = NCOLS > 1 ? $clog2(NCOLS) : 1;
    localparam int DW   = $clog2(SCAN_DIV);
    localparam int SW   = $clog2(DEBOUNCE + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int RC   = $clog2(NROWS + 1);

    logic [NROWS-1:0] rows_s1_q, rows_s2_q;
    logic [DW-1:0]    div_q;
    logic [CW-1:0]    col_q;
    logic [1:0]       acc_n_q, prev_n_q, res_n;
    logic [7:0]       acc_code_q, prev_code_q, res_code, s_code;
    logic [SW-1:0]    stable_q, stable_d;
    logic             held_q;
    logic [7:0]       held_code_q;
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]  count_q;
    logic             ovf_q;
    logic [RC-1:0]    s_cnt;
    logic             sample, frame_end, multi, same, commit, rel, prs, push, pop, wr_ok;
    logic [8:0]       ev;

    // Frame result: 0 = none, 1 = single key, 2 = multiple keys (ghost-prone, never committed)
    always_comb begin
        s_cnt  = '0;
        s_code = '0;
        for (int r = 0; r < NROWS; r++)
            if (rows_s2_q[r]) begin
                s_cnt  = s_cnt + 1'b1;
                s_code = 8'(r * NCOLS) + 8'(col_q);
            end
        sample    = div_q == DW'(SCAN_DIV - 1);
        frame_end = sample && col_q == CW'(NCOLS - 1);
        multi     = acc_n_q == 2'd2 || s_cnt > RC'(1) || (acc_n_q == 2'd1 && s_cnt == RC'(1));
        res_n     = multi ? 2'd2 : (acc_n_q == 2'd1 || s_cnt == RC'(1)) ? 2'd1 : 2'd0;
        res_code  = res_n != 2'd1 ? 8'd0 : acc_n_q == 2'd1 ? acc_code_q : s_code;
        same      = res_n == prev_n_q && res_code == prev_code_q;
        stable_d  = !same ? SW'(1) : stable_q == SW'(DEBOUNCE) ? stable_q : stable_q + 1'b1;
        commit    = frame_end && stable_d == SW'(DEBOUNCE);
        rel       = commit && res_n == 2'd0 && held_q;
        prs       = commit && res_n == 2'd1 && (!held_q || held_code_q != res_code);
        push      = prs || (rel && REPORT_REL != 0);
        ev        = {rel, rel ? held_code_q : res_code};
        pop       = rd_en && !empty;
        wr_ok     = push && (count_q != CNTW'(FIFO_DEPTH) || pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_s1_q   <= '0;
            rows_s2_q   <= '0;
            div_q       <= '0;
            col_q       <= '0;
            acc_n_q     <= '0;
            acc_code_q  <= '0;
            prev_n_q    <= '0;
            prev_code_q <= '0;
            stable_q    <= '0;
            held_q      <= 1'b0;
            held_code_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            rows_s1_q <= rows;
            rows_s2_q <= rows_s1_q;
            div_q     <= sample ? '0 : div_q + 1'b1;
            if (sample) begin
                col_q      <= frame_end ? '0 : col_q + 1'b1;
                acc_n_q    <= frame_end ? 2'd0 : res_n;
                acc_code_q <= frame_end ? 8'd0 : res_code;
            end
            if (frame_end) begin
                prev_n_q    <= res_n;
                prev_code_q <= res_code;
                stable_q    <= stable_d;
            end
            if (prs || rel) begin
                held_q      <= prs;
                held_code_q <= prs ? res_code : 8'd0;
            end
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNTW'(wr_ok) - CNTW'(pop);
            ovf_q   <= (push && !wr_ok) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
        end
    end

    always_ff @(posedge clk)
        if (wr_ok) mem_q[wr_ptr_q] <= ev;

    assign cols      = NCOLS'(1) << col_q;
    assign empty     = count_q == '0;
    assign count     = count_q;
    assign rd_data   = empty ? 32'd0 : {23'd0, mem_q[rd_ptr_q]};
    assign overflow  = ovf_q;
    assign key_held  = held_q;
    assign held_code = held_code_q;
endmodule
